game_flow_ctrl: RTL

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_flow_ctrl_if.sv | 22 ++
 rtl/game_flow_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl_if.sv
// Control and status bundle between the game flow controller and the rest of the game.
interface game_flow_ctrl_if;
    logic       start;
    logic       endGame;
    logic       gameFinished;
    logic       playEnable;
    logic       showWin;
    logic       showLose;
    logic [1:0] state;
    logic [7:0] playSeconds;
    logic [7:0] gamesPlayed;

    modport master (
        output start, endGame, gameFinished,
        input  playEnable, showWin, showLose, state, playSeconds, gamesPlayed
    );

    modport slave (
        input  start, endGame, gameFinished,
        output playEnable, showWin, showLose, state, playSeconds, gamesPlayed
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game flow sequencer: IDLE -> PLAY -> END_WIN/END_LOSE -> IDLE, with play-time
// seconds and a saturating games-started counter.
module game_flow_ctrl #(
    parameter int unsigned HOLD_CYCLES = 100_000_000,
    parameter int unsigned TICK_CYCLES = 100_000_000
) (
    input  logic           clk,
    input  logic           reset_n,
    game_flow_ctrl_if.slave bus
);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
    localparam int unsigned TICK_W = $clog2(TICK_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PLAY     = 2'b01,
        END_WIN  = 2'b10,
        END_LOSE = 2'b11
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                start_q;
    logic                play_en_q;
    logic                show_win_q;
    logic                show_lose_q;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [7:0]          secs_q;
    logic [7:0]          games_q;

    logic                start_press;
    logic                game_start;
    logic                end_hit;
    logic                tick_wrap;

    assign start_press = bus.start & ~start_q;

    // Next-state and control strobes; endGame outranks start in PLAY.
    always_comb begin
        state_d    = state_q;
        game_start = 1'b0;
        end_hit    = 1'b0;
        tick_wrap  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_press) begin
                    state_d    = PLAY;
                    game_start = 1'b1;
                end
            end
            PLAY: begin
                tick_wrap = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
                if (bus.endGame) begin
                    state_d = bus.gameFinished ? END_WIN : END_LOSE;
                    end_hit = 1'b1;
                end
            end
            END_WIN, END_LOSE: begin
                if (hold_cnt == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with registered one-hot status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b1;
            play_en_q   <= 1'b0;
            show_win_q  <= 1'b0;
            show_lose_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= bus.start;
            play_en_q   <= (state_d == PLAY);
            show_win_q  <= (state_d == END_WIN);
            show_lose_q <= (state_d == END_LOSE);
        end
    end

    // Hold, tick, seconds and games counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
            tick_cnt <= '0;
            secs_q   <= 8'd0;
            games_q  <= 8'd0;
        end else begin
            if (end_hit) begin
                hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
            end else if ((state_q == END_WIN || state_q == END_LOSE) && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end

            if (game_start) begin
                tick_cnt <= '0;
                secs_q   <= 8'd0;
                if (games_q != 8'hFF) begin
                    games_q <= games_q + 8'd1;
                end
            end else if (state_q == PLAY) begin
                if (tick_wrap) begin
                    tick_cnt <= '0;
                    if (secs_q != 8'hFF) begin
                        secs_q <= secs_q + 8'd1;
                    end
                end else begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                end
            end
        end
    end

    assign bus.state       = state_q;
    assign bus.playEnable  = play_en_q;
    assign bus.showWin     = show_win_q;
    assign bus.showLose    = show_lose_q;
    assign bus.playSeconds = secs_q;
    assign bus.gamesPlayed = games_q;
endmodule
